// File: rtl/npc_pkg.sv
// npc_pkg
// Shared definitions for the NPC core front end: RV32 major opcodes, the
// instruction format encoding used by decode and immediate generation, and
// the ALU operation enum handed to the EXU.
// No ports (package).
package npc_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    // Map funct3 of OP/OP-IMM onto an ALU operation; alt selects SUB/SRA.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen
// Combinational immediate generator for the RV32 base formats. All
// immediates sign-extend from inst[31]; R format yields zero.
// Ports:
//   inst  in  [31:7]   instruction word without the opcode field
//   fmt   in  3        instruction format (npc_pkg::fmt_e encoding)
//   imm   out XLEN     sign-extended immediate
module imm_gen #(
    parameter int XLEN = 32
) (
    input  logic [31:7]     inst,
    input  logic [2:0]      fmt,
    output logic [XLEN-1:0] imm
);
    import npc_pkg::*;

    logic [31:0] imm32;

    // Reassemble the scattered immediate bits for each format; B and J
    // offsets are halfword aligned so bit 0 is always zero.
    always_comb begin
        imm32 = 32'd0;
        case (fmt)
            FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm32 = {inst[31:12], 12'd0};
            FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/idu_stage.sv
// idu_stage
// RV32I/RV32E decode stage between IFU and EXU. Decodes one instruction per
// cycle, reads operands through the external register file, tracks pending
// register writes in a busy scoreboard to stall RAW hazards, and holds the
// decoded result in a one-entry output register.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      drop the output entry, block acceptance
//   in_valid/in_ready          IFU handshake; in_inst, in_pc payload
//   rf_raddr1/2, rf_rdata1/2   register file read ports (combinational)
//   wb_valid, wb_rd            writeback retire, clears busy[wb_rd]
//   out_valid/out_ready        EXU handshake
//   out_pc, out_src1/2, out_imm, out_rd, out_reg_wen, out_alu_op,
//   out_fmt, out_illegal       decoded instruction
module idu_stage #(
    parameter int XLEN   = 32,
    parameter int NR_REG = 32,
    parameter int RW     = $clog2(NR_REG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic [RW-1:0]   rf_raddr1,
    output logic [RW-1:0]   rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            wb_valid,
    input  logic [RW-1:0]   wb_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_src1,
    output logic [XLEN-1:0] out_src2,
    output logic [XLEN-1:0] out_imm,
    output logic [RW-1:0]   out_rd,
    output logic            out_reg_wen,
    output logic [3:0]      out_alu_op,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);
    import npc_pkg::*;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1_f, rs2_f, rd_f;
    logic [RW-1:0]   rs1_idx, rs2_idx, rd_idx;

    fmt_e            dec_fmt;
    alu_op_e         dec_alu;
    logic            dec_writes;
    logic            dec_bad;
    logic            use_rs1, use_rs2;
    logic            illegal;
    logic            haz1, haz2, hazard;
    logic            accept;
    logic            busy_set;
    logic [XLEN-1:0] imm;
    logic [NR_REG-1:0] busy, busy_next;

    assign opcode  = in_inst[6:0];
    assign rd_f    = in_inst[11:7];
    assign funct3  = in_inst[14:12];
    assign rs1_f   = in_inst[19:15];
    assign rs2_f   = in_inst[24:20];
    assign funct7  = in_inst[31:25];
    assign rs1_idx = rs1_f[RW-1:0];
    assign rs2_idx = rs2_f[RW-1:0];
    assign rd_idx  = rd_f[RW-1:0];

    assign rf_raddr1 = rs1_idx;
    assign rf_raddr2 = rs2_idx;

    // Opcode/funct decode: picks the format, ALU operation, whether the
    // instruction architecturally writes rd, and flags unknown encodings.
    always_comb begin
        dec_fmt    = FMT_I;
        dec_alu    = ALU_ADD;
        dec_writes = 1'b0;
        dec_bad    = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                dec_writes = 1'b1;
                dec_alu    = alu_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
                if ((funct3 == 3'b001) && (funct7 != 7'b0000000))
                    dec_bad = 1'b1;
                if ((funct3 == 3'b101) && (funct7 != 7'b0000000) && (funct7 != 7'b0100000))
                    dec_bad = 1'b1;
            end
            OPC_OP: begin
                dec_fmt    = FMT_R;
                dec_writes = 1'b1;
                dec_alu    = alu_from_f3(funct3, funct7[5]);
                if (!((funct7 == 7'b0000000) ||
                      ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))))
                    dec_bad = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_fmt    = FMT_U;
                dec_writes = 1'b1;
            end
            OPC_JAL: begin
                dec_fmt    = FMT_J;
                dec_writes = 1'b1;
            end
            OPC_JALR: begin
                dec_writes = 1'b1;
                dec_bad    = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec_fmt = FMT_B;
                case (funct3[2:1])
                    2'b00:   dec_alu = ALU_SUB;
                    2'b10:   dec_alu = ALU_SLT;
                    2'b11:   dec_alu = ALU_SLTU;
                    default: dec_bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec_writes = 1'b1;
                dec_bad    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                dec_fmt = FMT_S;
                dec_bad = funct3[2] || (funct3 == 3'b011);
            end
            OPC_SYSTEM: begin
                dec_bad = (in_inst != INST_ECALL) && (in_inst != INST_EBREAK);
            end
            default: dec_bad = 1'b1;
        endcase
    end

    assign use_rs1 = (dec_fmt != FMT_U) && (dec_fmt != FMT_J);
    assign use_rs2 = (dec_fmt == FMT_R) || (dec_fmt == FMT_S) || (dec_fmt == FMT_B);

    // Register indices are checked on the full 5-bit field so RV32E rejects
    // x16..x31 instead of silently aliasing them onto x0..x15.
    assign illegal = dec_bad
                   || (use_rs1    && ({1'b0, rs1_f} >= 6'(NR_REG)))
                   || (use_rs2    && ({1'b0, rs2_f} >= 6'(NR_REG)))
                   || (dec_writes && ({1'b0, rd_f}  >= 6'(NR_REG)));

    // A source conflicts with a retired-but-not-written-back producer (busy)
    // or with the producer still parked in our own output register.
    // Illegal instructions never stall since they do not really read.
    assign haz1 = use_rs1 && (rs1_f != 5'd0)
               && (busy[rs1_idx] || (out_valid && out_reg_wen && (out_rd == rs1_idx)));
    assign haz2 = use_rs2 && (rs2_f != 5'd0)
               && (busy[rs2_idx] || (out_valid && out_reg_wen && (out_rd == rs2_idx)));
    assign hazard = !illegal && (haz1 || haz2);

    assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst (in_inst[31:7]),
        .fmt  (dec_fmt),
        .imm  (imm)
    );

    // One-entry output register. Flush drops the entry; otherwise a new
    // instruction replaces it or a consumed entry empties the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_src1    <= '0;
            out_src2    <= '0;
            out_imm     <= '0;
            out_rd      <= '0;
            out_reg_wen <= 1'b0;
            out_alu_op  <= '0;
            out_fmt     <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_src1    <= use_rs1 ? rf_rdata1 : '0;
            out_src2    <= use_rs2 ? rf_rdata2 : '0;
            out_imm     <= imm;
            out_rd      <= dec_writes ? rd_idx : '0;
            out_reg_wen <= dec_writes && (rd_f != 5'd0) && !illegal;
            out_alu_op  <= dec_alu;
            out_fmt     <= dec_fmt;
            out_illegal <= illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // An entry discarded by flush is not a real handoff, so it must not
    // mark its destination busy even if the EXU side happened to be ready.
    assign busy_set = out_valid && out_ready && out_reg_wen && !flush;

    // Scoreboard update: writeback clears first so a same-index issue wins.
    always_comb begin
        busy_next = busy;
        if (wb_valid)
            busy_next[wb_rd] = 1'b0;
        if (busy_set)
            busy_next[out_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // Busy bits are registered, so a writeback clear is seen one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy <= '0;
        else
            busy <= busy_next;
    end

endmodule

// File: tb/tb_idu_stage.sv
// tb_idu_stage
// Directed bench for idu_stage: an RV32I instance (NR_REG=32) and an RV32E
// instance (NR_REG=16) share clock and reset. The register file model
// returns index*0x11111111 so operand routing is visible in out_src1/2.
module tb_idu_stage;
    import npc_pkg::*;

    logic        clk;
    logic        rst_n;

    logic        flush, in_valid, in_ready;
    logic [31:0] in_inst, in_pc;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_src1, out_src2, out_imm;
    logic [4:0]  out_rd;
    logic        out_reg_wen, out_illegal;
    logic [3:0]  out_alu_op;
    logic [2:0]  out_fmt;

    logic        e_flush, e_in_valid, e_in_ready;
    logic [31:0] e_in_inst, e_in_pc;
    logic [3:0]  e_rf_raddr1, e_rf_raddr2;
    logic [31:0] e_rf_rdata1, e_rf_rdata2;
    logic        e_wb_valid;
    logic [3:0]  e_wb_rd;
    logic        e_out_valid, e_out_ready;
    logic [31:0] e_out_pc, e_out_src1, e_out_src2, e_out_imm;
    logic [3:0]  e_out_rd;
    logic        e_out_reg_wen, e_out_illegal;
    logic [3:0]  e_out_alu_op;
    logic [2:0]  e_out_fmt;

    int testsRun = 0;
    int testsFailed = 0;

    assign rf_rdata1   = 32'(rf_raddr1)   * 32'h1111_1111;
    assign rf_rdata2   = 32'(rf_raddr2)   * 32'h1111_1111;
    assign e_rf_rdata1 = 32'(e_rf_raddr1) * 32'h1111_1111;
    assign e_rf_rdata2 = 32'(e_rf_raddr2) * 32'h1111_1111;

    idu_stage #(.XLEN(32), .NR_REG(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_src1(out_src1), .out_src2(out_src2), .out_imm(out_imm),
        .out_rd(out_rd), .out_reg_wen(out_reg_wen), .out_alu_op(out_alu_op),
        .out_fmt(out_fmt), .out_illegal(out_illegal)
    );

    idu_stage #(.XLEN(32), .NR_REG(16)) dut_e (
        .clk(clk), .rst_n(rst_n), .flush(e_flush),
        .in_valid(e_in_valid), .in_ready(e_in_ready), .in_inst(e_in_inst), .in_pc(e_in_pc),
        .rf_raddr1(e_rf_raddr1), .rf_raddr2(e_rf_raddr2),
        .rf_rdata1(e_rf_rdata1), .rf_rdata2(e_rf_rdata2),
        .wb_valid(e_wb_valid), .wb_rd(e_wb_rd),
        .out_valid(e_out_valid), .out_ready(e_out_ready),
        .out_pc(e_out_pc), .out_src1(e_out_src1), .out_src2(e_out_src2), .out_imm(e_out_imm),
        .out_rd(e_out_rd), .out_reg_wen(e_out_reg_wen), .out_alu_op(e_out_alu_op),
        .out_fmt(e_out_fmt), .out_illegal(e_out_illegal)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive the RV32I instance's IFU/EXU side, then let logic settle.
    task automatic applyStimulus(input logic valid, input logic [31:0] inst,
                                 input logic [31:0] pc, input logic ready);
        in_valid  = valid;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = ready;
        #1;
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Main directed sequence.
    initial begin
        rst_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
        wb_valid = 1'b0; wb_rd = '0; out_ready = 1'b0;
        e_flush = 1'b0; e_in_valid = 1'b0; e_in_inst = '0; e_in_pc = '0;
        e_wb_valid = 1'b0; e_wb_rd = '0; e_out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_pc", out_pc, 32'd0);
        checkOutput("rst_out_imm", out_imm, 32'd0);
        checkOutput("rst_out_src1", out_src1, 32'd0);
        checkOutput("rst_out_rd", 32'(out_rd), 32'd0);
        checkOutput("rst_out_wen", 32'(out_reg_wen), 32'd0);
        checkOutput("rst_out_illegal", 32'(out_illegal), 32'd0);
        checkOutput("rst_e_out_valid", 32'(e_out_valid), 32'd0);
        rst_n = 1'b1;

        // addi x1,x0,5 then addi x1,x0,-1 then lui x5,0x12345 back to back
        applyStimulus(1'b1, 32'h0050_0093, 32'h100, 1'b1);
        checkOutput("first_in_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("addi5_valid", 32'(out_valid), 32'd1);
        checkOutput("addi5_imm", out_imm, 32'd5);
        checkOutput("addi5_rd", 32'(out_rd), 32'd1);
        checkOutput("addi5_wen", 32'(out_reg_wen), 32'd1);
        checkOutput("addi5_fmt", 32'(out_fmt), 32'(FMT_I));
        checkOutput("addi5_alu", 32'(out_alu_op), 32'(ALU_ADD));
        checkOutput("addi5_src1", out_src1, 32'd0);
        checkOutput("addi5_src2_unused", out_src2, 32'd0);
        checkOutput("addi5_pc", out_pc, 32'h100);
        checkOutput("addi5_illegal", 32'(out_illegal), 32'd0);

        applyStimulus(1'b1, 32'hFFF0_0093, 32'h104, 1'b1);
        checkOutput("throughput_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("addim1_valid", 32'(out_valid), 32'd1);
        checkOutput("addim1_imm", out_imm, 32'hFFFF_FFFF);
        checkOutput("addim1_pc", out_pc, 32'h104);

        applyStimulus(1'b1, 32'h1234_52B7, 32'h108, 1'b1);
        tick();
        checkOutput("lui_imm", out_imm, 32'h1234_5000);
        checkOutput("lui_src1_unused", out_src1, 32'd0);
        checkOutput("lui_rd", 32'(out_rd), 32'd5);
        checkOutput("lui_fmt", 32'(out_fmt), 32'(FMT_U));

        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
        tick();
        checkOutput("drain_valid", 32'(out_valid), 32'd0);

        // addi x2,x1,1 must wait for x1's writeback, visible one cycle later
        applyStimulus(1'b1, 32'h0010_8113, 32'h10C, 1'b1);
        checkOutput("raw_busy_stall", 32'(in_ready), 32'd0);
        tick();
        checkOutput("raw_stall_valid", 32'(out_valid), 32'd0);
        checkOutput("raw_stall_ready", 32'(in_ready), 32'd0);
        wb_valid = 1'b1;
        wb_rd    = 5'd1;
        #1;
        checkOutput("raw_no_bypass", 32'(in_ready), 32'd0);
        tick();
        wb_valid = 1'b0;
        #1;
        checkOutput("raw_after_wb", 32'(in_ready), 32'd1);
        tick();
        checkOutput("addi2_valid", 32'(out_valid), 32'd1);
        checkOutput("addi2_src1", out_src1, 32'h1111_1111);
        checkOutput("addi2_imm", out_imm, 32'd1);
        checkOutput("addi2_rd", 32'(out_rd), 32'd2);

        // Backpressure for 3 cycles with dependent addi x6,x2,1 waiting
        applyStimulus(1'b1, 32'h0011_0313, 32'h110, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_pc", out_pc, 32'h10C);
            checkOutput("hold_src1", out_src1, 32'h1111_1111);
            checkOutput("hold_rd", 32'(out_rd), 32'd2);
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
        end
        applyStimulus(1'b1, 32'h0011_0313, 32'h110, 1'b1);
        checkOutput("held_producer_stall", 32'(in_ready), 32'd0);
        tick();
        checkOutput("held_consumed_valid", 32'(out_valid), 32'd0);
        checkOutput("held_busy_stall", 32'(in_ready), 32'd0);
        wb_valid = 1'b1;
        wb_rd    = 5'd2;
        tick();
        wb_valid = 1'b0;
        #1;
        checkOutput("x2_wb_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("addi6_src1", out_src1, 32'h2222_2222);
        checkOutput("addi6_rd", 32'(out_rd), 32'd6);

        // Independent addi x4,x0,7 accepted the same cycle out_ready rises
        applyStimulus(1'b1, 32'h0070_0213, 32'h114, 1'b0);
        checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        tick();
        checkOutput("bp_pc_stable", out_pc, 32'h110);
        applyStimulus(1'b1, 32'h0070_0213, 32'h114, 1'b1);
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("addi4_pc", out_pc, 32'h114);
        checkOutput("addi4_imm", out_imm, 32'd7);
        checkOutput("addi4_rd", 32'(out_rd), 32'd4);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
        tick();

        // Flush a held addi x3,x0,9; dependent addi x7,x3,2 must not stall
        applyStimulus(1'b1, 32'h0090_0193, 32'h118, 1'b0);
        tick();
        checkOutput("fl_pre_valid", 32'(out_valid), 32'd1);
        checkOutput("fl_pre_rd", 32'(out_rd), 32'd3);
        flush = 1'b1;
        applyStimulus(1'b1, 32'h0070_0213, 32'h11C, 1'b1);
        checkOutput("flush_blocks", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        checkOutput("flush_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 32'h0021_8393, 32'h120, 1'b1);
        checkOutput("flush_no_busy", 32'(in_ready), 32'd1);
        tick();
        checkOutput("addi7_src1", out_src1, 32'h3333_3333);
        checkOutput("addi7_rd", 32'(out_rd), 32'd7);

        // sw x2,8(x1); beq x0,x0,-4; jal x1,8; illegal all-ones word
        applyStimulus(1'b1, 32'h0020_A423, 32'h124, 1'b1);
        checkOutput("sw_in_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("sw_fmt", 32'(out_fmt), 32'(FMT_S));
        checkOutput("sw_imm", out_imm, 32'd8);
        checkOutput("sw_wen", 32'(out_reg_wen), 32'd0);
        checkOutput("sw_src1", out_src1, 32'h1111_1111);
        checkOutput("sw_src2", out_src2, 32'h2222_2222);
        applyStimulus(1'b1, 32'hFE00_0EE3, 32'h128, 1'b1);
        tick();
        checkOutput("beq_fmt", 32'(out_fmt), 32'(FMT_B));
        checkOutput("beq_imm", out_imm, 32'hFFFF_FFFC);
        checkOutput("beq_wen", 32'(out_reg_wen), 32'd0);
        applyStimulus(1'b1, 32'h0080_00EF, 32'h12C, 1'b1);
        tick();
        checkOutput("jal_fmt", 32'(out_fmt), 32'(FMT_J));
        checkOutput("jal_imm", out_imm, 32'd8);
        checkOutput("jal_wen", 32'(out_reg_wen), 32'd1);
        checkOutput("jal_rd", 32'(out_rd), 32'd1);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h130, 1'b1);
        tick();
        checkOutput("bad_illegal", 32'(out_illegal), 32'd1);
        checkOutput("bad_wen", 32'(out_reg_wen), 32'd0);

        // Asynchronous reset mid-stall drops the entry and clears busy[1]
        applyStimulus(1'b1, 32'h0010_8113, 32'h134, 1'b0);
        checkOutput("pre_rst_stall", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("async_rst_illegal", 32'(out_illegal), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_clears_busy", 32'(in_ready), 32'd1);
        tick();
        checkOutput("post_rst_src1", out_src1, 32'h1111_1111);
        checkOutput("post_rst_rd", 32'(out_rd), 32'd2);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);

        // RV32E: x16+ indices are illegal and never stall
        e_in_valid  = 1'b1;
        e_in_inst   = 32'h0050_0093;
        e_in_pc     = 32'h200;
        e_out_ready = 1'b1;
        tick();
        checkOutput("e_addi_valid", 32'(e_out_valid), 32'd1);
        checkOutput("e_addi_illegal", 32'(e_out_illegal), 32'd0);
        checkOutput("e_addi_wen", 32'(e_out_reg_wen), 32'd1);
        e_in_inst = 32'h0008_0093;
        #1;
        checkOutput("e_x16_ready", 32'(e_in_ready), 32'd1);
        tick();
        checkOutput("e_x16_illegal", 32'(e_out_illegal), 32'd1);
        checkOutput("e_x16_wen", 32'(e_out_reg_wen), 32'd0);
        e_in_inst = 32'h0008_8093;
        #1;
        checkOutput("e_x17_no_stall", 32'(e_in_ready), 32'd1);
        tick();
        checkOutput("e_x17_illegal", 32'(e_out_illegal), 32'd1);
        e_in_inst = 32'h0010_0893;
        tick();
        checkOutput("e_rd17_illegal", 32'(e_out_illegal), 32'd1);
        checkOutput("e_rd17_wen", 32'(e_out_reg_wen), 32'd0);
        e_in_inst = 32'h0010_8113;
        #1;
        checkOutput("e_x1_busy_stall", 32'(e_in_ready), 32'd0);
        e_in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
